mux_arb: RTL and testbench

MUX_ARB -- requirements
Module: mux_arb

---
 rtl/mux_arb_pkg.sv | 18 +
 rtl/mux_arb_if.sv | 31 +++
 rtl/mux_arb_mux2_w.sv | 18 +
 rtl/mux_arb.sv | 108 ++++++++++
 tb/tb_mux_arb.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants and the buffer occupancy encoding for mux_arb.
//   SEL_A / SEL_B : select values tagging which source a word came from
//   DEPTH_MAX     : the only supported output buffer depth
//   count_e       : buffer occupancy state (EMPTY/ONE/FULL)
package mux_arb_pkg;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   localparam int unsigned DEPTH_MAX = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } count_e;

endpackage

// File: rtl/mux_arb_if.sv
// mux_arb_if: handshake bundle for the two sources and the merged output.
//   a_valid/a_data/a_ready : source A (select 0)
//   b_valid/b_data/b_ready : source B (select 1)
//   z_valid/z_data/z_sel/z_ready : merged output with source tag
// Modports: master = the environment side, slave = the mux_arb side.
interface mux_arb_if #(
   parameter int unsigned WIDTH = 8
);

   logic             a_valid;
   logic [WIDTH-1:0] a_data;
   logic             a_ready;
   logic             b_valid;
   logic [WIDTH-1:0] b_data;
   logic             b_ready;
   logic             z_valid;
   logic [WIDTH-1:0] z_data;
   logic             z_sel;
   logic             z_ready;

   modport master (
      output a_valid, a_data, b_valid, b_data, z_ready,
      input  a_ready, b_ready, z_valid, z_data, z_sel
   );

   modport slave (
      input  a_valid, a_data, b_valid, b_data, z_ready,
      output a_ready, b_ready, z_valid, z_data, z_sel
   );

endinterface

// File: rtl/mux_arb_mux2_w.sv
// mux2_w: WIDTH-bit 2:1 selector; sel = SEL_A picks a, sel = SEL_B picks b.
//   sel : select bit
//   a,b : candidate words
//   y   : selected word (combinational)
module mux2_w
   import mux_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   assign y = (sel == SEL_B) ? b : a;

endmodule

// File: rtl/mux_arb.sv
// mux_arb: two-source arbiter merging A and B into one stream through a
// 2-entry output buffer; each word is tagged with the source it came from.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : mux_arb_if.slave (A/B source handshakes, Z output handshake)
// Build option: define MUX_ARB_RR_EN for round-robin arbitration when both
// sources are valid; otherwise A has fixed priority.
module mux_arb
   import mux_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = DEPTH_MAX
) (
   input  logic       clk,
   input  logic       reset,
   mux_arb_if.slave   bus
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   count_e           count_q;
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [DEPTH-1:0] sel_q;

`ifdef MUX_ARB_RR_EN
   logic             last_sel_q;
`endif

   logic             z_valid_c;
   logic             space_c;
   logic             grant_a_c;
   logic             grant_b_c;
   logic             push_c;
   logic             pop_c;
   logic [WIDTH-1:0] wdata_c;

   // Arbitration: a lone valid source wins; contention resolved by build option.
   always_comb begin
      grant_b_c = 1'b0;
      if (bus.b_valid && !bus.a_valid) begin
         grant_b_c = 1'b1;
      end
`ifdef MUX_ARB_RR_EN
      else if (bus.b_valid && bus.a_valid) begin
         grant_b_c = (last_sel_q == SEL_A);
      end
`endif
      grant_a_c = bus.a_valid && !grant_b_c;
   end

   // Handshake: space exists if not full or the head leaves this cycle.
   always_comb begin
      z_valid_c = (count_q != EMPTY);
      pop_c     = z_valid_c && bus.z_ready;
      space_c   = (count_q != FULL) || pop_c;
      push_c    = !reset && space_c && (grant_a_c || grant_b_c);
   end

   assign bus.a_ready = !reset && space_c && grant_a_c;
   assign bus.b_ready = !reset && space_c && grant_b_c;

   mux2_w #(.WIDTH(WIDTH)) u_wmux (
      .sel (grant_b_c),
      .a   (bus.a_data),
      .b   (bus.b_data),
      .y   (wdata_c)
   );

   // Buffer storage, pointers and occupancy state.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         sel_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
`ifdef MUX_ARB_RR_EN
         last_sel_q <= SEL_B;
`endif
      end else begin
         if (push_c) begin
            data_q[tail_q] <= wdata_c;
            sel_q[tail_q]  <= grant_b_c;
            tail_q         <= tail_q + PTR_W'(1);
`ifdef MUX_ARB_RR_EN
            last_sel_q     <= grant_b_c;
`endif
         end
         if (pop_c) begin
            head_q <= head_q + PTR_W'(1);
         end
         case ({push_c, pop_c})
            2'b10:   count_q <= (count_q == EMPTY) ? ONE : FULL;
            2'b01:   count_q <= (count_q == FULL) ? ONE : EMPTY;
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.z_valid = z_valid_c;
   assign bus.z_data  = data_q[head_q];
   assign bus.z_sel   = sel_q[head_q];

endmodule

// File: tb/tb_mux_arb.sv
// tb_mux_arb: directed scenarios plus a randomized queue-model run for mux_arb.
module tb_mux_arb;
   import mux_arb_pkg::*;

   localparam int unsigned WIDTH = 8;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   mux_arb_if #(.WIDTH(WIDTH)) bus ();

   mux_arb #(.WIDTH(WIDTH), .DEPTH(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.a_valid = 1'b0;
      bus.a_data  = '0;
      bus.b_valid = 1'b0;
      bus.b_data  = '0;
      bus.z_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      bus.a_valid = 1'b1;
      bus.a_data  = 8'h5A;
      bus.z_ready = 1'b1;
      tick();
      #1;
      checks++;
      if (bus.a_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_a_ready got=%b exp=0", bus.a_ready);
      end
      tick();
      checks++;
      if ({bus.z_valid, bus.z_sel, bus.z_data} !== 10'h000) begin
         failures++;
         $display("FAIL reset_outputs got v=%b s=%b d=%h exp all 0",
                  bus.z_valid, bus.z_sel, bus.z_data);
      end
      reset = 1'b0;
      idle_inputs();
      #1;
   endtask

   task automatic test_single();
      do_reset();
      bus.a_valid = 1'b1;
      bus.a_data  = 8'h3C;
      bus.z_ready = 1'b1;
      #1;
      checks++;
      if (bus.a_ready !== 1'b1 || bus.z_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_pre got rdy=%b zv=%b exp rdy=1 zv=0", bus.a_ready, bus.z_valid);
      end
      tick();
      bus.a_valid = 1'b0;
      bus.a_data  = 8'hFF;
      #1;
      checks++;
      if (bus.z_valid !== 1'b1 || bus.z_data !== 8'h3C || bus.z_sel !== 1'b0) begin
         failures++;
         $display("FAIL single_out got v=%b d=%h s=%b exp v=1 d=3c s=0",
                  bus.z_valid, bus.z_data, bus.z_sel);
      end
      tick();
      checks++;
      if (bus.z_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_drain got zv=%b exp 0", bus.z_valid);
      end
   endtask

   task automatic test_arbitration();
      logic [3:0] exp_sel;
`ifdef MUX_ARB_RR_EN
      exp_sel = 4'b1010;
`else
      exp_sel = 4'b0000;
`endif
      do_reset();
      bus.a_valid = 1'b1;
      bus.a_data  = 8'h11;
      bus.b_valid = 1'b1;
      bus.b_data  = 8'h22;
      bus.z_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (bus.a_ready !== !exp_sel[i] || bus.b_ready !== exp_sel[i]) begin
            failures++;
            $display("FAIL arb_ready[%0d] got a=%b b=%b exp a=%b b=%b",
                     i, bus.a_ready, bus.b_ready, !exp_sel[i], exp_sel[i]);
         end
         tick();
         checks++;
         if (bus.z_valid !== 1'b1 || bus.z_sel !== exp_sel[i] ||
             bus.z_data !== (exp_sel[i] ? 8'h22 : 8'h11)) begin
            failures++;
            $display("FAIL arb_out[%0d] got v=%b s=%b d=%h exp s=%b",
                     i, bus.z_valid, bus.z_sel, bus.z_data, exp_sel[i]);
         end
      end
      idle_inputs();
   endtask

   task automatic test_full();
      do_reset();
      bus.a_valid = 1'b1;
      bus.a_data  = 8'hA1;
      tick();
      bus.a_data  = 8'hA2;
      tick();
      bus.a_data  = 8'hA3;
      #1;
      checks++;
      if (bus.a_ready !== 1'b0 || dut.count_q !== FULL || bus.z_data !== 8'hA1) begin
         failures++;
         $display("FAIL full_hold got rdy=%b cnt=%0d d=%h exp rdy=0 cnt=2 d=a1",
                  bus.a_ready, dut.count_q, bus.z_data);
      end
      tick();
      checks++;
      if (bus.z_data !== 8'hA1 || bus.z_sel !== 1'b0 || dut.count_q !== FULL) begin
         failures++;
         $display("FAIL full_stable got d=%h s=%b cnt=%0d exp d=a1 s=0 cnt=2",
                  bus.z_data, bus.z_sel, dut.count_q);
      end
      bus.z_ready = 1'b1;
      #1;
      checks++;
      if (bus.a_ready !== 1'b1) begin
         failures++;
         $display("FAIL full_popspace got rdy=%b exp 1", bus.a_ready);
      end
      tick();
      bus.a_valid = 1'b0;
      #1;
      checks++;
      if (bus.z_data !== 8'hA2 || dut.count_q !== FULL) begin
         failures++;
         $display("FAIL full_swap got d=%h cnt=%0d exp d=a2 cnt=2", bus.z_data, dut.count_q);
      end
      tick();
      checks++;
      if (bus.z_data !== 8'hA3 || dut.count_q !== ONE) begin
         failures++;
         $display("FAIL full_drain got d=%h cnt=%0d exp d=a3 cnt=1", bus.z_data, dut.count_q);
      end
      tick();
      checks++;
      if (bus.z_valid !== 1'b0 || dut.count_q !== EMPTY) begin
         failures++;
         $display("FAIL full_empty got zv=%b cnt=%0d exp zv=0 cnt=0", bus.z_valid, dut.count_q);
      end
      idle_inputs();
   endtask

   task automatic test_push_pop();
      do_reset();
      bus.a_valid = 1'b1;
      bus.a_data  = 8'h55;
      tick();
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b1;
      bus.b_data  = 8'h77;
      bus.z_ready = 1'b1;
      #1;
      checks++;
      if (bus.z_data !== 8'h55 || bus.z_sel !== 1'b0 || bus.b_ready !== 1'b1) begin
         failures++;
         $display("FAIL pp_pre got d=%h s=%b brdy=%b exp d=55 s=0 brdy=1",
                  bus.z_data, bus.z_sel, bus.b_ready);
      end
      tick();
      bus.b_valid = 1'b0;
      #1;
      checks++;
      if (dut.count_q !== ONE || bus.z_data !== 8'h77 || bus.z_sel !== 1'b1) begin
         failures++;
         $display("FAIL pp_same got cnt=%0d d=%h s=%b exp cnt=1 d=77 s=1",
                  dut.count_q, bus.z_data, bus.z_sel);
      end
      tick();
      checks++;
      if (bus.z_valid !== 1'b0) begin
         failures++;
         $display("FAIL pp_drain got zv=%b exp 0", bus.z_valid);
      end
      idle_inputs();
   endtask

   task automatic test_reset_full();
      do_reset();
      bus.b_valid = 1'b1;
      bus.b_data  = 8'hB1;
      tick();
      bus.b_data  = 8'hB2;
      tick();
      checks++;
      if (dut.count_q !== FULL || bus.z_sel !== 1'b1) begin
         failures++;
         $display("FAIL rf_fill got cnt=%0d s=%b exp cnt=2 s=1", dut.count_q, bus.z_sel);
      end
      reset = 1'b1;
      bus.a_valid = 1'b1;
      bus.a_data  = 8'hC3;
      bus.b_valid = 1'b0;
      bus.z_ready = 1'b1;
      #1;
      checks++;
      if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
         failures++;
         $display("FAIL rf_ready got a=%b b=%b exp 0 0", bus.a_ready, bus.b_ready);
      end
      tick();
      reset = 1'b0;
      bus.a_valid = 1'b0;
      #1;
      checks++;
      if (bus.z_valid !== 1'b0 || dut.count_q !== EMPTY || bus.z_data !== 8'h00 ||
          bus.z_sel !== 1'b0) begin
         failures++;
         $display("FAIL rf_after got zv=%b cnt=%0d d=%h s=%b exp 0 0 00 0",
                  bus.z_valid, dut.count_q, bus.z_data, bus.z_sel);
      end
      tick();
      checks++;
      if (bus.z_valid !== 1'b0) begin
         failures++;
         $display("FAIL rf_dropped got zv=%b exp 0", bus.z_valid);
      end
      idle_inputs();
   endtask

   task automatic test_random();
      logic [WIDTH:0] q[$];
      logic m_last;
      logic m_zv;
      logic m_space;
      logic m_gb;
      logic exp_ar;
      logic exp_br;
      int   bad;
      do_reset();
      m_last = 1'b1;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         bus.a_valid = 1'($urandom);
         bus.a_data  = WIDTH'($urandom);
         bus.b_valid = 1'($urandom);
         bus.b_data  = WIDTH'($urandom);
         bus.z_ready = 1'($urandom);
         #1;
         m_zv    = (q.size() != 0);
         m_space = (q.size() < 2) || (m_zv && bus.z_ready);
         m_gb    = bus.b_valid && !bus.a_valid;
`ifdef MUX_ARB_RR_EN
         if (bus.a_valid && bus.b_valid) m_gb = (m_last == 1'b0);
`endif
         exp_ar = m_space && bus.a_valid && !m_gb;
         exp_br = m_space && m_gb;
         checks++;
         if (bus.a_ready !== exp_ar || bus.b_ready !== exp_br || bus.z_valid !== m_zv) begin
            failures++;
            if (bad < 10) $display("FAIL rnd_hs[%0d] got a=%b b=%b zv=%b exp a=%b b=%b zv=%b",
                                   i, bus.a_ready, bus.b_ready, bus.z_valid, exp_ar, exp_br, m_zv);
            bad++;
         end
         if (m_zv) begin
            checks++;
            if ({bus.z_sel, bus.z_data} !== q[0]) begin
               failures++;
               if (bad < 10) $display("FAIL rnd_data[%0d] got s=%b d=%h exp s=%b d=%h",
                                      i, bus.z_sel, bus.z_data, q[0][WIDTH], q[0][WIDTH-1:0]);
               bad++;
            end
         end
         @(posedge clk);
         if (m_zv && bus.z_ready) void'(q.pop_front());
         if (exp_ar || exp_br) begin
            q.push_back({m_gb, m_gb ? bus.b_data : bus.a_data});
            m_last = m_gb;
         end
         #1;
      end
      idle_inputs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      idle_inputs();
      #1;
      test_reset();
      test_single();
      test_arbitration();
      test_full();
      test_push_pop();
      test_reset_full();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
